fp_mul_norm_round: RTL and testbench
====================================

Name: fp_mul_norm_round

Overview:
- Final stage of the pipelined single-precision FP multiplier. Sits directly downstream of the mantissa-product carry-lookahead adder and the exponent adder.
- Consumes the 48-bit unsigned mantissa product, the unbiased-sum exponent, the sign and special-case flags.
- Normalizes, rounds to nearest-even, checks exponent range and packs the IEEE-754 binary32 result.
- Two-stage pipeline with a valid/ready handshake.

Parameters:
- MANT_W, 24, significand width including hidden bit (product width = 2*MANT_W).
- EXP_W, 10, two's-complement width of the incoming exponent.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage 1 can accept.
- in_sign  in  1  sign_a XOR sign_b.
- in_exp  in  EXP_W  ea + eb - BIAS (biased result exponent before normalization), signed.
- in_prod  in  2*MANT_W  mantissa product, normal operands, so the value lies in [2^46, 2^48).
- in_nan / in_inf / in_zero  in  1 each  special-case flags from operand decode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  32  packed binary32.
- out_ovf / out_unf / out_inexact  out  1 each  exception flags for this result.

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, all flags 0. in_ready=1 once reset is released. A reset mid-operation discards in-flight beats; no partial output appears.
- Handshake:
  - adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1.
  - A transfer occurs when valid & ready.
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - Latency is 2 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Stage 1 (normalize), registered when adv1:
  - n = in_prod[47].
  - If n=1: mant = P[47:24], G = P[23], R = P[22], S = |P[21:0].
  - If n=0: mant = P[46:23], G = P[22], R = P[21], S = |P[20:0].
  - exp1 = in_exp + n, sign-extended to EXP_W+1.
  - Special flags, sign and valid are carried along.
- Stage 2 (round/pack), registered when adv2:
  - up = G & (R | S | mant[0]); inexact = G | R | S.
  - m25 = mant + up. If m25[24] = 1, frac = 0 and exp2 = exp1 + 1; else frac = m25[22:0] and exp2 = exp1.
  - Overflow, exp2 >= 255: result = {sign, 8'hFF, 23'h0}, ovf=1, inexact=1.
  - Underflow, exp2 <= 0: flush to {sign, 31'h0}, unf=1, inexact=1. No denormal outputs.
  - Otherwise: {sign, exp2[7:0], frac}.
- Special override, priority nan > inf > zero; it suppresses all flags:
  - nan gives 32'h7FC00000.
  - inf gives {sign, 8'hFF, 23'h0}. (inf × 0 is signalled upstream as nan.)
  - zero gives {sign, 31'h0}.
- Flags are valid only with out_valid and are replaced on every new result.
- A simultaneous accept in stage 1 and drain of stage 2 in the same cycle is legal: full throughput with no bubble.

Decomposition:
- Shared package fp_mul_pkg: BIAS, EXP_MAX=255, QNAN=32'h7FC00000, MANT_W/EXP_W, and a typedef for the stage-1 payload (sign, exp1, mant, G, R, S, special flags).
- One combinational sub-module, rne_round: inputs mant, G, R, S; outputs m25 and inexact. It is reused by the planned FP adder pipeline.

Test Plan:
- 1.5×1.5: in_exp=127, in_prod=48'h900000000000, sign 0 → out_result 32'h40100000 after 2 cycles; all flags 0.
- Tie round-to-even up: in_exp=127, in_prod=48'h400000C00000 → 32'h3F800002, inexact=1. Tie with even lsb: in_prod=48'h400000400000 → 32'h3F800000, inexact=1.
- Round carry-out: in_exp=127, in_prod=48'h7FFFFFE00000 → 32'h40000000, inexact=1.
- Range:
  - Overflow: in_exp=254, in_prod[47]=1 → 32'h7F800000, ovf=1.
  - Underflow: in_exp=0, prod=48'h400000000000 → 32'h00000000, unf=1.
  - Specials: in_nan=1 with in_inf=1 → 32'h7FC00000; in_zero=1 with sign 1 → 32'h80000000.
- Backpressure and reset:
  - Stream 4 beats with out_ready=0 → in_ready falls after 2 accepts; out_result is stable for the whole stall.
  - Releasing out_ready delivers the results in order with no loss or duplication.
  - rst_n pulsed low mid-stream → out_valid=0 immediately (asynchronous); the next beat after release appears at latency 2.

Source files
------------

// File: rtl/fp_mul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_mul_pkg : shared constants and stage-1 payload for the FP multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
package fp_mul_pkg;

    localparam int          MANT_W  = 24;
    localparam int          EXP_W   = 10;
    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    // Normalized significand plus rounding bits, carried from stage 1 to stage 2
    typedef struct packed {
        logic              sign;
        logic [EXP_W:0]    exp1;
        logic [MANT_W-1:0] mant;
        logic              g;
        logic              r;
        logic              s;
        logic              nan;
        logic              inf;
        logic              zero;
    } s1_payload_t;

endpackage
`default_nettype wire

// File: rtl/fp_mul_norm_round_rne_round.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rne_round : round-to-nearest-even increment of a significand (combinational)
// Rev 1.0
// ---------------------------------------------------------------------------
module rne_round #(
    parameter int MANT_W = 24
) (
    input  logic [MANT_W-1:0] mant,
    input  logic              g,
    input  logic              r,
    input  logic              s,
    output logic [MANT_W:0]   m25,
    output logic              inexact
);

    logic up;

    // Ties (g set, r and s clear) round toward the even significand
    assign up      = g & (r | s | mant[0]);
    assign m25     = {1'b0, mant} + {{MANT_W{1'b0}}, up};
    assign inexact = g | r | s;

endmodule
`default_nettype wire

// File: rtl/fp_mul_norm_round.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_mul_norm_round : normalize, RNE round, range check and binary32 pack
// Rev 1.0
// ---------------------------------------------------------------------------
module fp_mul_norm_round #(
    parameter int MANT_W = fp_mul_pkg::MANT_W,
    parameter int EXP_W  = fp_mul_pkg::EXP_W,
    parameter int BIAS   = fp_mul_pkg::BIAS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [2*MANT_W-1:0]   in_prod,
    input  logic                  in_nan,
    input  logic                  in_inf,
    input  logic                  in_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_result,
    output logic                  out_ovf,
    output logic                  out_unf,
    output logic                  out_inexact
);

    import fp_mul_pkg::*;

    localparam logic [EXP_W:0] EXP_LIM = (EXP_W+1)'(2*BIAS + 1);

    logic        s1_valid;
    logic        s2_valid;
    logic        adv1;
    logic        adv2;
    s1_payload_t s1;
    s1_payload_t s1_next;
    logic        n;

    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;
    assign n        = in_prod[2*MANT_W-1];

    // Stage 1: pick the 24 significant bits and the guard/round/sticky below them
    always_comb begin
        s1_next      = '0;
        s1_next.sign = in_sign;
        s1_next.nan  = in_nan;
        s1_next.inf  = in_inf;
        s1_next.zero = in_zero;
        s1_next.exp1 = {in_exp[EXP_W-1], in_exp} + (EXP_W+1)'(n);
        if (n) begin
            s1_next.mant = in_prod[2*MANT_W-1 -: MANT_W];
            s1_next.g    = in_prod[MANT_W-1];
            s1_next.r    = in_prod[MANT_W-2];
            s1_next.s    = |in_prod[MANT_W-3:0];
        end else begin
            s1_next.mant = in_prod[2*MANT_W-2 -: MANT_W];
            s1_next.g    = in_prod[MANT_W-2];
            s1_next.r    = in_prod[MANT_W-3];
            s1_next.s    = |in_prod[MANT_W-4:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= s1_next;
            end
        end
    end

    logic [MANT_W:0]   m25;
    logic              rnd_inexact;
    logic [EXP_W:0]    exp2;
    logic [MANT_W-2:0] frac;
    logic [31:0]       res_next;
    logic              ovf_next;
    logic              unf_next;
    logic              inx_next;

    rne_round #(
        .MANT_W (MANT_W)
    ) u_rne_round (
        .mant    (s1.mant),
        .g       (s1.g),
        .r       (s1.r),
        .s       (s1.s),
        .m25     (m25),
        .inexact (rnd_inexact)
    );

    // A rounding carry-out leaves 1.000..0, so only the exponent moves;
    // a clear hidden bit without carry cannot occur for normal operands.
    assign exp2 = s1.exp1 + (EXP_W+1)'(m25[MANT_W]);
    assign frac = (m25[MANT_W] || !m25[MANT_W-1]) ? '0 : m25[MANT_W-2:0];

    always_comb begin
        res_next = {s1.sign, exp2[7:0], frac};
        ovf_next = 1'b0;
        unf_next = 1'b0;
        inx_next = rnd_inexact;
        if (s1.nan) begin
            res_next = QNAN;
            inx_next = 1'b0;
        end else if (s1.inf) begin
            res_next = {s1.sign, 8'hFF, 23'h0};
            inx_next = 1'b0;
        end else if (s1.zero) begin
            res_next = {s1.sign, 31'h0};
            inx_next = 1'b0;
        end else if (!exp2[EXP_W] && (exp2 >= EXP_LIM)) begin
            res_next = {s1.sign, 8'hFF, 23'h0};
            ovf_next = 1'b1;
            inx_next = 1'b1;
        end else if (exp2[EXP_W] || (exp2 == '0)) begin
            res_next = {s1.sign, 31'h0};
            unf_next = 1'b1;
            inx_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= res_next;
                out_ovf     <= ovf_next;
                out_unf     <= unf_next;
                out_inexact <= inx_next;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_norm_round.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fp_mul_norm_round : randomized and directed bench with reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fp_mul_norm_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_prod;
    logic        in_nan;
    logic        in_inf;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    int          n_vec;
    int          n_err;
    int          rdy_mode;
    logic [34:0] sb[$];

    fp_mul_norm_round u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_prod     (in_prod),
        .in_nan      (in_nan),
        .in_inf      (in_inf),
        .in_zero     (in_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: treat the product as an integer, divide by 2^shift and round
    // the quotient to nearest-even using the exact remainder.
    function automatic logic [34:0] model(input logic s, input logic [9:0] e,
                                          input logic [47:0] p, input logic nan,
                                          input logic inf, input logic zero);
        longint unsigned pp, q, rem, half;
        int              sh, ex;
        logic            inx;
        logic [22:0]     f;
        logic [7:0]      eb;
        if (nan)  return {32'h7FC0_0000, 3'b000};
        if (inf)  return {s, 8'hFF, 23'h0, 3'b000};
        if (zero) return {s, 31'h0, 3'b000};
        sh   = p[47] ? 24 : 23;
        pp   = 64'(p);
        q    = pp >> sh;
        rem  = pp - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        ex = int'($signed(e)) + (p[47] ? 1 : 0);
        if (q == (64'd1 << 24)) begin
            q  = q / 2;
            ex = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 23'h0, 3'b101};
        if (ex <= 0)   return {s, 31'h0, 3'b011};
        f  = 23'(q % (64'd1 << 23));
        eb = 8'(ex);
        return {s, eb, f, 2'b00, inx};
    endfunction

    // Drive one beat from just after a rising edge; returns just after the accepting edge
    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] p,
                        input logic nan, input logic inf, input logic zero,
                        input logic [34:0] expv);
        int t;
        in_sign  = s;
        in_exp   = e;
        in_prod  = p;
        in_nan   = nan;
        in_inf   = inf;
        in_zero  = zero;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            sb.push_back(expv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic s, input logic [9:0] e, input logic [47:0] p,
                          input logic nan, input logic inf, input logic zero);
        send(s, e, p, nan, inf, zero, model(s, e, p, nan, inf, zero));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1:       out_ready = 1'b0;
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: in-order scoreboard plus stability under stall
    initial begin
        logic        hold_v;
        logic [34:0] held;
        logic [34:0] expv;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v)
                    check("stall_hold", {out_valid, out_result, out_ovf, out_unf, out_inexact},
                          {1'b1, held});
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", {out_result, out_ovf, out_unf, out_inexact}, 64'd0);
                    end else begin
                        expv = sb.pop_front();
                        check("result", out_result, expv[34:3]);
                        check("flags", {out_ovf, out_unf, out_inexact}, expv[2:0]);
                    end
                    hold_v = 1'b0;
                end else if (out_valid) begin
                    hold_v = 1'b1;
                    held   = {out_result, out_ovf, out_unf, out_inexact};
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [47:0] p;
        logic [9:0]  e;
        int          k;
        n_vec    = 0;
        n_err    = 0;
        rdy_mode = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = '0;
        in_prod  = '0;
        in_nan   = 1'b0;
        in_inf   = 1'b0;
        in_zero  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {out_valid, out_result, out_ovf, out_unf, out_inexact}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived results
        send(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0, {32'h4010_0000, 3'b000});
        send(0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, {32'h3F80_0002, 3'b001});
        send(0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, {32'h3F80_0000, 3'b001});
        send(0, 10'd127, 48'h7FFF_FFE0_0000, 0, 0, 0, {32'h4000_0000, 3'b001});
        send(0, 10'd254, 48'h8000_0000_0000, 0, 0, 0, {32'h7F80_0000, 3'b101});
        send(0, 10'd0,   48'h4000_0000_0000, 0, 0, 0, {32'h0000_0000, 3'b011});
        send(1, 10'd127, 48'h4000_00C0_0000, 1, 1, 0, {32'h7FC0_0000, 3'b000});
        send(1, 10'd127, 48'h9000_0000_0000, 0, 0, 1, {32'h8000_0000, 3'b000});
        send(1, 10'd3,   48'hC000_0000_0000, 0, 1, 1, {32'hFF80_0000, 3'b000});
        send(1, 10'd1,   48'h4000_0000_0000, 0, 0, 0, {32'h8080_0000, 3'b000});
        send(0, 10'h3FF, 48'h8000_0000_0000, 0, 0, 0, {32'h0000_0000, 3'b011});
        drain();

        // Backpressure: two accepts fill the pipe, the third must wait
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send_m(0, 10'd130, 48'h9123_4567_89AB, 0, 0, 0);
        send_m(1, 10'd100, 48'h5555_5555_5555, 0, 0, 0);
        in_sign  = 0;
        in_exp   = 10'd127;
        in_prod  = 48'hABCD_EF01_2345;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        repeat (4) @(negedge clk);
        check("bp_out_valid", {out_valid, in_ready}, 2'b10);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_m(0, 10'd127, 48'hABCD_EF01_2345, 0, 0, 0);
        send_m(1, 10'd200, 48'hFFFF_FFFF_FFFF, 0, 0, 0);
        drain();

        // Asynchronous reset mid-stream, then latency of the next beat
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        send_m(0, 10'd50, 48'h6000_0000_0001, 0, 0, 0);
        send_m(0, 10'd60, 48'h7000_0000_0001, 0, 0, 0);
        @(posedge clk);
        #3;
        check("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {out_valid, out_result, out_ovf, out_unf, out_inexact}, 64'd0);
        sb.delete();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_m(0, 10'd127, 48'h9000_0000_0000, 0, 0, 0);
        @(negedge clk);
        check("lat_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check("lat_cycle2", out_valid, 1'b1);
        drain();
        @(posedge clk);
        #1;

        // Randomized traffic with random output stalls and input gaps
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            p = {$urandom(), $urandom()};
            p[47:46] = 2'($urandom_range(1, 3));
            k = $urandom_range(0, 3);
            if (k == 0) begin
                p[22:0] = '0;
                p[23]   = 1'b1;
            end else if (k == 1) begin
                p[21:0] = '0;
                p[22]   = 1'b1;
            end else if (k == 2) begin
                p[46:23] = '1;
            end
            if ($urandom_range(0, 2) == 0) e = 10'($urandom());
            else                           e = 10'($urandom_range(0, 300) - 20);
            if ($urandom_range(0, 7) == 0)
                send_m(1'($urandom()), e, p, 1'($urandom()), 1'($urandom()), 1'($urandom()));
            else
                send_m(1'($urandom()), e, p, 1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
